// File: rtl/intr_host_agent_if.sv
// Acknowledge handshake lines between the host agent and the 8-input interrupt controller.
// The shared data bus stays a plain inout port so tristate resolution happens at module boundaries.
interface intr_host_agent_if;
    logic pic_intr;
    logic pic_oe;
    logic pic_ack_n;

    modport master (
        input  pic_intr,
        input  pic_oe,
        output pic_ack_n
    );

    modport slave (
        output pic_intr,
        output pic_oe,
        input  pic_ack_n
    );
endinterface

// File: rtl/intr_host_agent.sv
// Processor-side agent for the 8-input interrupt controller: programs it once after reset,
// then runs acknowledge / vector fetch / end-of-interrupt and hands vectors to the ISR layer.
module intr_host_agent #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                i_cfg_start,
    input  logic                i_cfg_mode,
    input  logic [23:0]         i_cfg_prio,
    output logic                o_cfg_done,
    intr_host_agent_if.master   pic,
    inout  wire  [7:0]          io_pic_bus,
    output logic                o_isr_req,
    output logic [2:0]          o_isr_vec,
    input  logic                i_isr_done,
    output logic [CNT_W-1:0]    o_irq_count,
    output logic                o_err
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CFG      = 3'd1;
    localparam logic [2:0] S_WAIT_INT = 3'd2;
    localparam logic [2:0] S_ACK      = 3'd3;
    localparam logic [2:0] S_ISR      = 3'd4;
    localparam logic [2:0] S_EOI      = 3'd5;

    localparam int         TCNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [4:0] VEC_HDR    = 5'b01011;
    localparam logic [4:0] EOI_HDR    = 5'b10100;
    localparam logic [7:0] POLL_CMD   = 8'h01;

    logic [2:0]        r_state;
    logic [1:0]        r_byte_cnt;
    logic              r_mode;
    logic [23:0]       r_prio;
    logic              r_drv;
    logic [7:0]        r_bus;
    logic              r_ack_n;
    logic              r_cfg_done;
    logic              r_isr_req;
    logic [2:0]        r_isr_vec;
    logic [CNT_W-1:0]  r_irq_count;
    logic              r_err;
    logic [TCNT_W-1:0] r_tcnt;

    logic              w_contention;
    logic              w_drive;
    logic [1:0]        w_last_byte;
    logic [4:0]        w_bus_hdr;

    // Priority command byte j packs table entries 2j and 2j+1 above the 2'b10 opcode.
    function automatic logic [7:0] prio_byte(input logic [23:0] prio, input logic [1:0] j);
        logic [5:0] pair;
        case (j)
            2'd0:    pair = prio[5:0];
            2'd1:    pair = prio[11:6];
            2'd2:    pair = prio[17:12];
            default: pair = prio[23:18];
        endcase
        return {pair[2:0], pair[5:3], 2'b10};
    endfunction

    // The bus is released in the same cycle the controller claims it, so the guard is combinational.
    assign w_contention = r_drv & pic.pic_oe;
    assign w_drive      = r_drv & ~pic.pic_oe;
    assign io_pic_bus   = w_drive ? r_bus : 8'hzz;
    assign w_last_byte  = r_mode ? 2'd3 : 2'd0;
    assign w_bus_hdr    = io_pic_bus[7:3];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_mode      <= 1'b0;
            r_prio      <= 24'd0;
            r_drv       <= 1'b0;
            r_bus       <= 8'd0;
            r_ack_n     <= 1'b1;
            r_cfg_done  <= 1'b0;
            r_isr_req   <= 1'b0;
            r_isr_vec   <= 3'd0;
            r_irq_count <= '0;
            r_err       <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_cfg_done <= 1'b0;
            r_isr_req  <= 1'b0;
            if (w_contention) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        r_mode     <= i_cfg_mode;
                        r_prio     <= i_cfg_prio;
                        r_byte_cnt <= 2'd0;
                        r_bus      <= i_cfg_mode ? prio_byte(i_cfg_prio, 2'd0) : POLL_CMD;
                        r_drv      <= 1'b1;
                        r_state    <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (r_byte_cnt == w_last_byte) begin
                        r_drv      <= 1'b0;
                        r_cfg_done <= 1'b1;
                        r_state    <= S_WAIT_INT;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_bus      <= prio_byte(r_prio, r_byte_cnt + 2'd1);
                    end
                end
                S_WAIT_INT: begin
                    if (pic.pic_intr) begin
                        r_ack_n <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    // A vector arriving on the last allowed cycle still beats the timeout.
                    if (pic.pic_oe) begin
                        r_ack_n <= 1'b1;
                        if (w_bus_hdr == VEC_HDR) begin
                            r_isr_vec <= io_pic_bus[2:0];
                            r_isr_req <= 1'b1;
                            r_state   <= S_ISR;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_WAIT_INT;
                        end
                    end else if (r_tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_ack_n <= 1'b1;
                        r_state <= S_WAIT_INT;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_ISR: begin
                    if (i_isr_done) begin
                        r_bus   <= {EOI_HDR, r_isr_vec};
                        r_drv   <= 1'b1;
                        r_ack_n <= 1'b0;
                        r_state <= S_EOI;
                    end
                end
                S_EOI: begin
                    // Ack must rise after exactly one cycle or it would acknowledge the next request.
                    r_drv       <= 1'b0;
                    r_ack_n     <= 1'b1;
                    r_irq_count <= r_irq_count + CNT_W'(1);
                    r_state     <= S_WAIT_INT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pic.pic_ack_n = r_ack_n;
    assign o_cfg_done    = r_cfg_done;
    assign o_isr_req     = r_isr_req;
    assign o_isr_vec     = r_isr_vec;
    assign o_irq_count   = r_irq_count;
    assign o_err         = r_err;
endmodule

// File: tb/tb_intr_host_agent.sv
// Self-checking bench for intr_host_agent: table vectors, hand-written corner sequences,
// and a randomized interrupt stream against a transaction-level model.
module tb_intr_host_agent;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 8;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic        cfgStart;
    logic        cfgMode;
    logic [23:0] cfgPrio;
    logic        cfgDone;
    logic        isrReq;
    logic [2:0]  isrVec;
    logic        isrDone;
    logic [7:0]  irqCount;
    logic        err;
    logic        tbOe;
    logic [7:0]  tbData;
    tri1  [7:0]  picBus;

    int checkCount = 0;
    int errorCount = 0;

    intr_host_agent_if picIf ();

    assign picBus = tbOe ? tbData : 8'hzz;

    intr_host_agent #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_in      (clkIn),
        .rst_in      (rstIn),
        .i_cfg_start (cfgStart),
        .i_cfg_mode  (cfgMode),
        .i_cfg_prio  (cfgPrio),
        .o_cfg_done  (cfgDone),
        .pic         (picIf),
        .io_pic_bus  (picBus),
        .o_isr_req   (isrReq),
        .o_isr_vec   (isrVec),
        .i_isr_done  (isrDone),
        .o_irq_count (irqCount),
        .o_err       (err)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic            mode;
        logic [23:0]     prio;
        logic            holdIntr;
        int              nBytes;
        logic [3:0][7:0] expBytes;
    } cfgVec_t;

    typedef struct {
        logic [7:0] busByte;
        int         ackDelay;
        logic       expErr;
        logic [2:0] expVec;
        logic [7:0] expEoi;
        logic [7:0] expCount;
    } intrVec_t;

    cfgVec_t  cfgTab  [3];
    intrVec_t intrTab [5];

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {7'd0, actual}, {7'd0, expected});
    endtask

    task automatic applyStimulus(input logic intr, input logic oe, input logic [7:0] data, input logic done);
        picIf.pic_intr = intr;
        picIf.pic_oe   = oe;
        tbOe           = oe;
        tbData         = data;
        isrDone        = done;
    endtask

    task automatic stepCycle();
        @(posedge clkIn);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "BusZ"}, picBus, 8'hFF);
        checkBit({tag, "AckN"}, picIf.pic_ack_n, 1'b1);
        checkBit({tag, "CfgDone"}, cfgDone, 1'b0);
        checkBit({tag, "IsrReq"}, isrReq, 1'b0);
        checkBit({tag, "Err"}, err, 1'b0);
        checkOutput({tag, "IsrVec"}, {5'd0, isrVec}, 8'd0);
        checkOutput({tag, "IrqCount"}, irqCount, 8'd0);
    endtask

    task automatic doReset();
        rstIn    = 1'b1;
        cfgStart = 1'b0;
        cfgMode  = 1'b0;
        cfgPrio  = 24'd0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        stepCycle();
        stepCycle();
        rstIn = 1'b0;
        stepCycle();
    endtask

    // Expected command bytes computed from the table entries with plain arithmetic.
    function automatic logic [3:0][7:0] modelCfgBytes(input logic mode, input logic [23:0] prio);
        logic [3:0][7:0] b;
        int entry [8];
        b = '0;
        for (int k = 0; k < 8; k++) entry[k] = int'((prio >> (3 * k)) & 24'd7);
        if (!mode) b[0] = 8'd1;
        else for (int j = 0; j < 4; j++) b[j] = 8'(entry[2*j] * 32 + entry[2*j+1] * 4 + 2);
        return b;
    endfunction

    task automatic runConfig(input logic mode, input logic [23:0] prio, input logic holdIntr,
                             input int nBytes, input logic [3:0][7:0] expBytes);
        cfgMode  = mode;
        cfgPrio  = prio;
        cfgStart = 1'b1;
        if (holdIntr) picIf.pic_intr = 1'b1;
        stepCycle();
        cfgStart = 1'b0;
        for (int k = 0; k < nBytes; k++) begin
            if (k > 0) stepCycle();
            checkOutput("cfgByte", picBus, expBytes[k]);
            checkBit("cfgAckN", picIf.pic_ack_n, 1'b1);
            checkBit("cfgDoneEarly", cfgDone, 1'b0);
        end
        stepCycle();
        checkOutput("cfgBusZ", picBus, 8'hFF);
        checkBit("cfgDone", cfgDone, 1'b1);
        picIf.pic_intr = 1'b0;
        stepCycle();
        checkBit("cfgDonePulse", cfgDone, 1'b0);
        checkBit("cfgIdleAckN", picIf.pic_ack_n, 1'b1);
    endtask

    // One request from pic_intr through EOI; stops after the vector cycle when the header is bad.
    task automatic runInterrupt(input logic [7:0] busByte, input int ackDelay, input logic badHdr,
                                input logic errAfter, input logic [2:0] expVec, input logic [7:0] expEoi,
                                input logic [7:0] expCount, input int isrDelay, input logic noise);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkBit("ackLow", picIf.pic_ack_n, 1'b0);
        for (int d = 0; d < ackDelay; d++) begin
            stepCycle();
            checkBit("ackHeld", picIf.pic_ack_n, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, busByte, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkBit("vecAckN", picIf.pic_ack_n, 1'b1);
        checkBit("vecErr", err, errAfter);
        if (badHdr) begin
            checkBit("badHdrIsrReq", isrReq, 1'b0);
            stepCycle();
            checkBit("badHdrAckIdle", picIf.pic_ack_n, 1'b1);
            return;
        end
        checkBit("isrReq", isrReq, 1'b1);
        checkOutput("isrVec", {5'd0, isrVec}, {5'd0, expVec});
        for (int d = 0; d < isrDelay; d++) begin
            picIf.pic_intr = noise;
            cfgStart       = noise & 1'($urandom_range(0, 1));
            stepCycle();
            checkBit("isrReqPulse", isrReq, 1'b0);
            checkBit("isrAckIdle", picIf.pic_ack_n, 1'b1);
        end
        cfgStart = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("eoiBus", picBus, expEoi);
        checkBit("eoiAckN", picIf.pic_ack_n, 1'b0);
        stepCycle();
        checkOutput("eoiRelease", picBus, 8'hFF);
        checkBit("eoiAckRise", picIf.pic_ack_n, 1'b1);
        checkOutput("irqCount", irqCount, expCount);
        checkBit("eoiErr", err, errAfter);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int          modelCount;
        logic        modelErr;
        logic        bad;
        int          hdr;
        logic [2:0]  vec;
        logic [7:0]  busByte;
        logic        rMode;
        logic [23:0] rPrio;

        cfgTab[0] = '{1'b0, 24'hABCDEF, 1'b0, 1, 32'h0000_0001};
        cfgTab[1] = '{1'b1, 24'o01234567, 1'b0, 4, 32'h226A_B2FA};
        cfgTab[2] = '{1'b1, 24'o76543210, 1'b1, 4, 32'hDE96_4E06};

        intrTab[0] = '{8'h5D, 0,  1'b0, 3'd5, 8'hA5, 8'd1};
        intrTab[1] = '{8'h58, 2,  1'b0, 3'd0, 8'hA0, 8'd2};
        intrTab[2] = '{8'h5F, 15, 1'b0, 3'd7, 8'hA7, 8'd3};
        intrTab[3] = '{8'h5B, 1,  1'b0, 3'd3, 8'hA3, 8'd4};
        intrTab[4] = '{8'h3D, 0,  1'b1, 3'd0, 8'h00, 8'd4};

        rstIn = 1'b1;
        cfgStart = 1'b0;
        cfgMode = 1'b0;
        cfgPrio = 24'd0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checkResetState("reset");

        for (int i = 0; i < 3; i++) begin
            doReset();
            runConfig(cfgTab[i].mode, cfgTab[i].prio, cfgTab[i].holdIntr, cfgTab[i].nBytes, cfgTab[i].expBytes);
        end

        doReset();
        runConfig(1'b0, 24'd0, 1'b0, 1, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            runInterrupt(intrTab[i].busByte, intrTab[i].ackDelay, intrTab[i].expErr, intrTab[i].expErr,
                         intrTab[i].expVec, intrTab[i].expEoi, intrTab[i].expCount, 2, 1'b0);
        end

        // Acknowledge timeout, then a normal request still gets through.
        doReset();
        runConfig(1'b0, 24'd0, 1'b0, 1, 32'h0000_0001);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (picIf.pic_ack_n == 1'b0 && n < 40) begin
            n++;
            stepCycle();
        end
        checkOutput("timeoutCycles", 8'(n), 8'(ACK_TIMEOUT));
        checkBit("timeoutErr", err, 1'b1);
        checkBit("timeoutAckN", picIf.pic_ack_n, 1'b1);
        runInterrupt(8'h5A, 0, 1'b0, 1'b1, 3'd2, 8'hA2, 8'd1, 1, 1'b0);

        // Controller claims the bus while the agent is sending a command byte.
        doReset();
        cfgMode = 1'b1;
        cfgPrio = 24'o01234567;
        cfgStart = 1'b1;
        stepCycle();
        cfgStart = 1'b0;
        checkOutput("contentionByte0", picBus, 8'hFA);
        stepCycle();
        picIf.pic_oe = 1'b1;
        #1;
        checkOutput("contentionDrop", picBus, 8'hFF);
        stepCycle();
        picIf.pic_oe = 1'b0;
        #1;
        checkBit("contentionErr", err, 1'b1);
        checkOutput("contentionResume", picBus, 8'h6A);

        // Reset during ISR.
        doReset();
        runConfig(1'b0, 24'd0, 1'b0, 1, 32'h0000_0001);
        runInterrupt(8'h5E, 0, 1'b0, 1'b0, 3'd6, 8'hA6, 8'd1, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 8'h5D, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkBit("preResetIsrReq", isrReq, 1'b1);
        #2;
        rstIn = 1'b1;
        #1;
        checkResetState("isrReset");
        stepCycle();
        rstIn = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle();
        stepCycle();
        checkBit("idleIgnoresIntr", picIf.pic_ack_n, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset while the second priority byte is on the bus.
        doReset();
        cfgMode = 1'b1;
        cfgPrio = 24'o01234567;
        cfgStart = 1'b1;
        stepCycle();
        cfgStart = 1'b0;
        stepCycle();
        checkOutput("cfgByte2", picBus, 8'hB2);
        #2;
        rstIn = 1'b1;
        #1;
        checkResetState("cfgReset");
        stepCycle();
        rstIn = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("cfgNoResume", picBus, 8'hFF);
        checkBit("cfgNoDone", cfgDone, 1'b0);

        // cfg_start held together with reset is discarded.
        rstIn = 1'b1;
        cfgStart = 1'b1;
        stepCycle();
        cfgStart = 1'b0;
        rstIn = 1'b0;
        stepCycle();
        checkOutput("rstWinsBus", picBus, 8'hFF);
        stepCycle();
        checkBit("rstWinsDone", cfgDone, 1'b0);

        // Random stream: wraps the counter, bad headers only near the end so err stays 0 through the wrap.
        doReset();
        rMode = 1'($urandom_range(0, 1));
        rPrio = 24'($urandom);
        runConfig(rMode, rPrio, 1'b0, rMode ? 4 : 1, modelCfgBytes(rMode, rPrio));
        modelCount = 0;
        modelErr = 1'b0;
        for (int t = 0; t < 300; t++) begin
            vec = 3'($urandom_range(0, 7));
            bad = (t >= 270) && ($urandom_range(0, 9) == 0);
            if (bad) begin
                hdr = int'($urandom_range(0, 30));
                if (hdr >= 11) hdr++;
                busByte = 8'(hdr * 8 + int'(vec));
                modelErr = 1'b1;
            end else begin
                busByte = 8'(88 + int'(vec));
                modelCount = (modelCount + 1) % 256;
            end
            runInterrupt(busByte, int'($urandom_range(0, 3)), bad, modelErr, vec, 8'(160 + int'(vec)),
                         8'(modelCount), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
